// File: rtl/banked_memory_manager.sv
// Banked word RAM plus a peripheral region (LEDs, push-button, bank fill engine).
// Define BMM_BUTTON_IRQ_EN to enable the sticky button event and irq_o.
module banked_memory_manager #(
  parameter int L       = 8,
  parameter int A       = 32,
  parameter int NBANKS  = 4,
  parameter int DEPTH_W = 10,
  parameter int SEL_LSB = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         req_i,
  input  logic         wren_i,
  input  logic [A-1:0] address_i,
  input  logic [L-1:0] data_i,
  input  logic         button_i,
  output logic         ready_o,
  output logic         rvalid_o,
  output logic [L-1:0] data_o,
  output logic [7:0]   LEDs_o,
  output logic         irq_o
);

  localparam int BW = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam logic [2:0] PERIPH_SEL = 3'b111;
  localparam logic STATE_IDLE = 1'b0;
  localparam logic STATE_FILL = 1'b1;

  logic [L-1:0] mem [0:NBANKS-1][0:(1<<DEPTH_W)-1];

  logic [2:0]         sel;
  logic [DEPTH_W-1:0] bank_off;
  logic [3:0]         periph_off;
  logic [BW-1:0]      bank_idx;
  logic               bank_hit;
  logic               periph_hit;

  logic               state;
  logic [DEPTH_W-1:0] cnt;
  logic [BW-1:0]      fill_bank;
  logic [L-1:0]       fill_value;
  logic               btn_meta;
  logic               btn_sync;
  logic               sticky;

  logic               accept;
  logic               acc_wr;
  logic               acc_rd;
  logic               fill_start;
  logic [L-1:0]       rd_data;
  logic               unused_bits;

  assign sel        = address_i[SEL_LSB+2:SEL_LSB];
  assign bank_off   = address_i[DEPTH_W-1:0];
  assign periph_off = address_i[3:0];
  assign bank_idx   = sel[BW-1:0];
  assign bank_hit   = (sel < 3'(NBANKS));
  assign periph_hit = (sel == PERIPH_SEL);

  assign ready_o = (state == STATE_IDLE);
  assign accept  = req_i & ready_o;
  assign acc_wr  = accept & wren_i;
  assign acc_rd  = accept & ~wren_i;

  // A start request naming a bank that does not exist is silently dropped.
  assign fill_start = acc_wr & periph_hit & (periph_off == 4'd2) & data_i[3] &
                      (data_i[2:0] < 3'(NBANKS));

  assign unused_bits = ^{address_i, data_i};

  // Bank RAM is deliberately unreset; the fill engine owns the write port while busy.
  always_ff @(posedge CLK) begin
    if (state == STATE_FILL) begin
      mem[fill_bank][cnt] <= fill_value;
    end else if (acc_wr && bank_hit) begin
      mem[bank_idx][bank_off] <= data_i;
    end
  end

  always_comb begin
    rd_data = '0;
    if (bank_hit) begin
      rd_data = mem[bank_idx][bank_off];
    end else if (periph_hit) begin
      case (periph_off)
        4'd0:    rd_data[7:0] = LEDs_o;
        4'd1:    rd_data[1:0] = {sticky, btn_sync};
        4'd3:    rd_data      = fill_value;
        4'd4:    rd_data[0]   = (state == STATE_FILL);
        default: rd_data      = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= STATE_IDLE;
      cnt       <= '0;
      fill_bank <= '0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (fill_start) begin
            state     <= STATE_FILL;
            cnt       <= '0;
            fill_bank <= data_i[BW-1:0];
          end
        end
        STATE_FILL: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state <= STATE_IDLE;
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      LEDs_o     <= '0;
      fill_value <= '0;
    end else if (acc_wr && periph_hit) begin
      if (periph_off == 4'd0) begin
        LEDs_o <= data_i[7:0];
      end
      if (periph_off == 4'd3) begin
        fill_value <= data_i;
      end
    end
  end

  // data_o holds the last read result until the next accepted read replaces it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rvalid_o <= 1'b0;
      data_o   <= '0;
    end else begin
      rvalid_o <= acc_rd;
      if (acc_rd) begin
        data_o <= rd_data;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= button_i;
      btn_sync <= btn_meta;
    end
  end

`ifdef BMM_BUTTON_IRQ_EN
  logic btn_prev;

  // A rising edge seen in the same cycle as a clear request keeps the event pending.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      btn_prev <= 1'b0;
      sticky   <= 1'b0;
    end else begin
      btn_prev <= btn_sync;
      if (btn_sync && !btn_prev) begin
        sticky <= 1'b1;
      end else if (acc_wr && periph_hit && (periph_off == 4'd1) && data_i[1]) begin
        sticky <= 1'b0;
      end
    end
  end
`else
  assign sticky = 1'b0;
`endif

  assign irq_o = sticky;

endmodule

// File: tb/tb_banked_memory_manager.sv
// Randomised and directed bench for banked_memory_manager against a word-level
// model of banks, peripherals and fill timing.
module tb_banked_memory_manager;

  localparam int L       = 8;
  localparam int A       = 32;
  localparam int NBANKS  = 4;
  localparam int DEPTH_W = 10;
  localparam int SEL_LSB = 16;
  localparam int DEPTH   = 1 << DEPTH_W;
`ifdef BMM_BUTTON_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST;
  logic         req_i;
  logic         wren_i;
  logic [A-1:0] address_i;
  logic [L-1:0] data_i;
  logic         button_i;
  logic         ready_o;
  logic         rvalid_o;
  logic [L-1:0] data_o;
  logic [7:0]   LEDs_o;
  logic         irq_o;

  banked_memory_manager #(
    .L(L), .A(A), .NBANKS(NBANKS), .DEPTH_W(DEPTH_W), .SEL_LSB(SEL_LSB)
  ) dut (
    .CLK(CLK), .RST(RST), .req_i(req_i), .wren_i(wren_i), .address_i(address_i),
    .data_i(data_i), .button_i(button_i), .ready_o(ready_o), .rvalid_o(rvalid_o),
    .data_o(data_o), .LEDs_o(LEDs_o), .irq_o(irq_o)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [L-1:0] model_mem   [NBANKS][DEPTH];
  bit           model_known [NBANKS][DEPTH];
  logic [7:0]   model_leds;
  logic [L-1:0] model_fill_val;
  logic [L-1:0] model_data;
  bit           model_data_known;
  int           fill_left;
  bit           model_btn;
  bit           model_sticky;
  logic         sampled_ready;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [A-1:0] bankAddr(input int bank, input int offset);
    logic [A-1:0] a;
    logic [31:0]  b;
    logic [31:0]  o;
    a = $urandom;
    b = bank;
    o = offset;
    a[SEL_LSB+2:SEL_LSB] = b[2:0];
    a[DEPTH_W-1:0]       = o[DEPTH_W-1:0];
    return a;
  endfunction

  function automatic logic [A-1:0] periphAddr(input int offset);
    logic [A-1:0] a;
    logic [31:0]  o;
    a = $urandom;
    o = offset;
    a[SEL_LSB+2:SEL_LSB] = 3'b111;
    a[3:0]               = o[3:0];
    return a;
  endfunction

  task automatic modelReset();
    model_leds       = '0;
    model_fill_val   = '0;
    model_data       = '0;
    model_data_known = 1'b1;
    fill_left        = 0;
    model_sticky     = 1'b0;
    model_btn        = 1'b0;
  endtask

  // One clock cycle of traffic: the model decides acceptance from its own fill countdown.
  task automatic applyStimulus(input logic req, input logic wren, input logic [A-1:0] addr,
                               input logic [L-1:0] data);
    bit   exp_ready;
    bit   acc;
    bit   exp_rvalid;
    int   sel;
    int   boff;
    int   off;
    int   fb;
    @(negedge CLK);
    req_i     = req;
    wren_i    = wren;
    address_i = addr;
    data_i    = data;
    #1;
    exp_ready     = (fill_left == 0);
    sampled_ready = ready_o;
    checkOutput("ready", ready_o, exp_ready);
    acc = req && exp_ready;
    @(posedge CLK);
    #1;
    if (fill_left > 0) fill_left--;
    exp_rvalid = acc && !wren;
    sel  = int'(addr[SEL_LSB+2:SEL_LSB]);
    boff = int'(addr[DEPTH_W-1:0]);
    off  = int'(addr[3:0]);
    if (acc) begin
      if (sel < NBANKS) begin
        if (wren) begin
          model_mem[sel][boff]   = data;
          model_known[sel][boff] = 1'b1;
        end else begin
          model_data       = model_mem[sel][boff];
          model_data_known = model_known[sel][boff];
        end
      end else if (sel == 7) begin
        if (wren) begin
          case (off)
            0: model_leds = data[7:0];
            1: if (data[1]) model_sticky = 1'b0;
            2: begin
              fb = int'(data[2:0]);
              if (data[3] && fb < NBANKS) begin
                fill_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) begin
                  model_mem[fb][i]   = model_fill_val;
                  model_known[fb][i] = 1'b1;
                end
              end
            end
            3: model_fill_val = data;
            default: ;
          endcase
        end else begin
          model_data       = '0;
          model_data_known = 1'b1;
          case (off)
            0: model_data[7:0] = model_leds;
            1: model_data[1:0] = {model_sticky & IRQ_EN, model_btn};
            3: model_data      = model_fill_val;
            default: ;
          endcase
        end
      end else if (!wren) begin
        model_data       = '0;
        model_data_known = 1'b1;
      end
    end
    checkOutput("rvalid", rvalid_o, exp_rvalid);
    if (model_data_known) checkOutput("data", data_o, model_data);
    checkOutput("leds", LEDs_o, model_leds);
  endtask

  initial begin
    int kind;
    int low;
    bit done;
    bit seen;
    int poffs [6] = '{0, 1, 3, 4, 5, 9};

    RST       = 1'b1;
    req_i     = 1'b0;
    wren_i    = 1'b0;
    address_i = '0;
    data_i    = '0;
    button_i  = 1'b0;
    for (int b = 0; b < NBANKS; b++)
      for (int i = 0; i < DEPTH; i++) model_known[b][i] = 1'b0;
    modelReset();

    #2 RST = 1'b0;
    #1;
    checkOutput("rst_ready", ready_o, 1);
    checkOutput("rst_rvalid", rvalid_o, 0);
    checkOutput("rst_data", data_o, 0);
    checkOutput("rst_leds", LEDs_o, 0);
    checkOutput("rst_irq", irq_o, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    applyStimulus(1, 1, bankAddr(2, 7), 8'hA5);
    applyStimulus(1, 0, bankAddr(2, 7), 8'h00);
    checkOutput("a5_rvalid", rvalid_o, 1);
    checkOutput("a5_data", data_o, 8'hA5);
    applyStimulus(0, 0, '0, '0);

    applyStimulus(1, 1, periphAddr(0), 8'h3C);
    checkOutput("leds_3c", LEDs_o, 8'h3C);
    applyStimulus(1, 0, periphAddr(0), 8'h00);
    checkOutput("leds_read", data_o, 8'h3C);

    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 4)
        applyStimulus($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
                      bankAddr($urandom_range(0, NBANKS - 1), $urandom_range(0, 15)), 8'($urandom));
      else if (kind <= 6)
        applyStimulus($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
                      bankAddr($urandom_range(4, 6), $urandom_range(0, 15)), 8'($urandom));
      else
        applyStimulus($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
                      periphAddr(poffs[$urandom_range(0, 5)]), 8'($urandom));
    end

    applyStimulus(1, 1, periphAddr(3), 8'h11);
    applyStimulus(1, 1, periphAddr(2), 8'h09);
    low  = 0;
    done = 1'b0;
    for (int i = 0; i < DEPTH + 10 && !done; i++) begin
      applyStimulus(1, 1, bankAddr(0, 5), 8'hEE);
      if (sampled_ready) done = 1'b1;
      else low++;
    end
    checkOutput("fill_len", low, DEPTH);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, bankAddr(1, i), 8'h00);
    checkOutput("fill_last", data_o, 8'h11);
    for (int i = 0; i < 16; i++) applyStimulus(1, 0, bankAddr(0, i), 8'h00);

    applyStimulus(1, 1, periphAddr(2), 8'h0E);
    applyStimulus(1, 0, periphAddr(4), 8'h00);
    checkOutput("bad_idx_ready", sampled_ready, 1);
    checkOutput("bad_idx_busy", data_o, 0);

    button_i = 1'b1;
    seen     = 1'b0;
    for (int i = 0; i < 3 && !seen; i++) begin
      applyStimulus(0, 0, '0, '0);
      if (irq_o) seen = 1'b1;
    end
    checkOutput("irq_rise", irq_o, IRQ_EN);
    model_btn    = 1'b1;
    model_sticky = IRQ_EN;
    applyStimulus(1, 0, periphAddr(1), 8'h00);
    checkOutput("btn_status", data_o, {IRQ_EN, 1'b1});
    button_i = 1'b0;
    repeat (3) applyStimulus(0, 0, '0, '0);
    model_btn = 1'b0;
    checkOutput("irq_sticky", irq_o, IRQ_EN);
    applyStimulus(1, 1, periphAddr(1), 8'h02);
    applyStimulus(0, 0, '0, '0);
    checkOutput("irq_clear", irq_o, 0);

    applyStimulus(1, 1, periphAddr(2), 8'h0B);
    repeat (100) applyStimulus(1, 0, bankAddr(1, 3), 8'h00);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checkOutput("midfill_ready", ready_o, 1);
    checkOutput("midfill_rvalid", rvalid_o, 0);
    checkOutput("midfill_data", data_o, 0);
    checkOutput("midfill_leds", LEDs_o, 0);
    checkOutput("midfill_irq", irq_o, 0);
    @(negedge CLK);
    RST = 1'b1;
    modelReset();
    for (int i = 0; i < DEPTH; i++) model_known[3][i] = 1'b0;
    applyStimulus(1, 0, periphAddr(3), 8'h00);
    applyStimulus(1, 0, periphAddr(4), 8'h00);
    applyStimulus(1, 0, bankAddr(1, 0), 8'h00);
    checkOutput("post_rst_bank1", data_o, 8'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/banked_memory_manager.md
BANKED_MEMORY_MANAGER -- requirements
Module: banked_memory_manager

Interface
REQ-001 SHALL have parameter L, default 8: data word width in bits (range 8..32).
REQ-002 SHALL have parameter A, default 32: address width in bits.
REQ-003 SHALL have parameter NBANKS, default 4: number of internal RAM banks (range 1..7).
REQ-004 SHALL have parameter DEPTH_W, default 10: bank address width; each bank holds 2**DEPTH_W words.
REQ-005 SHALL have parameter SEL_LSB, default 16: LSB of the 3-bit region select field address_i[SEL_LSB+2:SEL_LSB].
REQ-006 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port RST, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port req_i, input, 1 bit: access request.
REQ-009 SHALL have port wren_i, input, 1 bit: write when 1, read when 0; qualified by req_i.
REQ-010 SHALL have port address_i, input, A bits: byte-free word address.
REQ-011 SHALL have port data_i, input, L bits: write data.
REQ-012 SHALL have port button_i, input, 1 bit: asynchronous push-button.
REQ-013 SHALL have port ready_o, output, 1 bit: access accepted this cycle when req_i and ready_o are both 1.
REQ-014 SHALL have port rvalid_o, output, 1 bit: data_o is valid.
REQ-015 SHALL have port data_o, output, L bits: read data.
REQ-016 SHALL have port LEDs_o, output, 8 bits: LED register.
REQ-017 SHALL have port irq_o, output, 1 bit: button event interrupt.

Function
REQ-018 SHALL decode sel = address_i[SEL_LSB+2:SEL_LSB]: sel < NBANKS selects bank sel at offset address_i[DEPTH_W-1:0]; sel = 3'b111 selects peripherals at offset address_i[3:0]; any other sel is unmapped.
REQ-019 SHALL write a bank word on the rising edge of an accepted write; unmapped writes have no effect.
REQ-020 SHALL return read data with fixed 1-cycle latency: rvalid_o = 1 exactly in the cycle after an accepted read, and data_o holds its value until the next rvalid_o.
REQ-021 SHALL register sel together with the read so that data_o comes from the region addressed at acceptance; unmapped reads return 0 with rvalid_o = 1.
REQ-022 SHALL implement peripheral offsets as follows: 0 = LED register, R/W, bits[7:0]; 1 = button status, R, bit0 = synchronised level, bit1 = sticky event; 2 = fill control, W, bits[2:0] = bank index, bit3 = start; 3 = fill value, R/W; 4 = status, R, bit0 = busy. Other offsets read 0 and ignore writes.
REQ-023 SHALL synchronise button_i through two flip-flops before any use.
REQ-024 SHALL implement a fill FSM with states IDLE and FILL: a write to offset 2 with bit3 = 1 and bank index < NBANKS moves IDLE->FILL; an index >= NBANKS is ignored.
REQ-025 SHALL in FILL write the fill value to bank word cnt, with cnt running from 0 to 2**DEPTH_W-1 (one word per cycle), then return to IDLE; fill duration is exactly 2**DEPTH_W cycles.
REQ-026 SHALL hold ready_o = 0 while in FILL and 1 in IDLE; requests during FILL are not accepted and have no effect.
REQ-027 SHALL give an accepted access in the same cycle as FILL->IDLE normal service in the following cycle only; ready_o is combinational from state.
REQ-028 SHALL zero-extend LED, status and button values narrower than L to L bits.

Reset
REQ-029 SHALL asynchronously on RST = 0 force: LEDs_o = 0, fill value = 0, FSM = IDLE, cnt = 0, data_o = 0, rvalid_o = 0, synchroniser flops = 0, sticky event = 0, irq_o = 0.
REQ-030 SHALL leave bank RAM contents unreset; reset during FILL aborts the fill, with partially filled contents undefined.

Configuration
REQ-031 SHALL, with BMM_BUTTON_IRQ_EN defined, set sticky event on a synchronised 0->1 edge, clear it on a write to offset 1 with bit1 = 1 (a same-cycle edge wins), and drive irq_o = sticky event.
REQ-032 SHALL, without BMM_BUTTON_IRQ_EN, read status bit1 as 0 and tie irq_o to 0.

Verification
REQ-033 SHALL cover: write 0xA5 to bank 2 offset 7, then read it -> rvalid_o one cycle later, data_o = 0xA5.
REQ-034 SHALL cover: write 0x3C to offset 0 of sel 7 -> LEDs_o = 0x3C next cycle; read offset 0 -> 0x3C.
REQ-035 SHALL cover: fill value 0x11, start fill on bank 1 -> ready_o low for exactly 2**DEPTH_W cycles; all words of bank 1 read 0x11 and bank 0 is unchanged.
REQ-036 SHALL cover: start fill with bank index 6 when NBANKS = 4 -> busy stays 0 and ready_o stays 1.
REQ-037 SHALL cover: with BMM_BUTTON_IRQ_EN, pulse button_i -> irq_o = 1 within 3 cycles; write 0x2 to offset 1 -> irq_o = 0; assert RST mid-fill -> ready_o = 1 and all outputs at reset values.
